// File: rtl/puzzle_move_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puzzle_move_sequencer_pkg
//  Description : Shared definitions for the 8-puzzle move sequencer: ALU
//                opcodes, move codes, board field slices, FSM encoding and
//                small helpers for move-code to opcode / inverse mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package puzzle_move_sequencer_pkg;

    localparam int BOARD_W   = 40;
    localparam int BLANK_MSB = 39;
    localparam int BLANK_LSB = 36;
    localparam logic [3:0] MAX_POS = 4'd8;

    // ALU opcodes shared with the 40-bit 8-puzzle ALU
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] COMP     = 4'h1;
    localparam logic [3:0] TO_UP    = 4'h2;
    localparam logic [3:0] TO_DOWN  = 4'h3;
    localparam logic [3:0] TO_LEFT  = 4'h4;
    localparam logic [3:0] to_right = 4'h5;

    // Move codes: direction the blank moves
    localparam logic [1:0] MV_UP    = 2'd0;
    localparam logic [1:0] MV_DOWN  = 2'd1;
    localparam logic [1:0] MV_LEFT  = 2'd2;
    localparam logic [1:0] MV_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_WAIT_MV = 3'd2,
        S_APPLY   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic [3:0] blank_of(input logic [BOARD_W-1:0] board);
        return board[BLANK_MSB:BLANK_LSB];
    endfunction

    function automatic logic [3:0] op_of_code(input logic [1:0] code);
        logic [3:0] op;
        case (code)
            MV_UP:   op = TO_UP;
            MV_DOWN: op = TO_DOWN;
            MV_LEFT: op = TO_LEFT;
            default: op = to_right;
        endcase
        return op;
    endfunction

    // UP<->DOWN and LEFT<->RIGHT differ only in the low bit
    function automatic logic [1:0] inv_code(input logic [1:0] code);
        return {code[1], ~code[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/puzzle_move_legal.sv
`default_nettype none
// ============================================================================
//  Module      : puzzle_move_legal
//  Description : Combinational legality check for a blank-tile move on the
//                3x3 board, plus the ALU opcode and inverse move code.
//  Revision    : 1.0 - initial release
// ============================================================================
module puzzle_move_legal
    import puzzle_move_sequencer_pkg::*;
(
    input  logic [3:0] i_pos,
    input  logic [1:0] i_code,
    output logic       o_legal,
    output logic [3:0] o_opcode,
    output logic [1:0] o_inv_code
);

    logic w_on_board;
    logic w_top_row;
    logic w_bot_row;
    logic w_left_col;
    logic w_right_col;

    assign w_on_board  = (i_pos <= MAX_POS);
    assign w_top_row   = (i_pos <= 4'd2);
    assign w_bot_row   = (i_pos >= 4'd6);
    assign w_left_col  = (i_pos == 4'd0) || (i_pos == 4'd3) || (i_pos == 4'd6);
    assign w_right_col = (i_pos == 4'd2) || (i_pos == 4'd5) || (i_pos == 4'd8);

    // A move is legal when the blank's target cell stays on the 3x3 grid
    always_comb begin
        o_legal = 1'b0;
        case (i_code)
            MV_UP:   o_legal = w_on_board && !w_top_row;
            MV_DOWN: o_legal = w_on_board && !w_bot_row;
            MV_LEFT: o_legal = w_on_board && !w_left_col;
            default: o_legal = w_on_board && !w_right_col;
        endcase
    end

    assign o_opcode   = op_of_code(i_code);
    assign o_inv_code = inv_code(i_code);

endmodule
`default_nettype wire

// File: rtl/puzzle_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : puzzle_move_sequencer
//  Description : Sequences the shared 8-puzzle ALU: loads start/goal boards,
//                accepts blank-tile moves, applies legal ones through the
//                ALU and compares each result against the goal.
//                Optional macro UNDO_EN adds mv_undo and a move-history LIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module puzzle_move_sequencer
    import puzzle_move_sequencer_pkg::*;
#(
    parameter int MAX_MOVES  = 31,
    parameter int CNT_W      = 8,
    parameter int UNDO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [39:0]       start_board,
    input  logic [39:0]       goal_board,
    input  logic              mv_valid,
    output logic              mv_ready,
    input  logic [1:0]        mv_code,
    output logic              mv_illegal,
    output logic              done,
    input  logic              done_ack,
`ifdef UNDO_EN
    input  logic              mv_undo,
`endif
    output logic              solved,
    output logic              bad_board,
    output logic              busy,
    output logic [CNT_W-1:0]  move_cnt,
    output logic [39:0]       board_out,
    output logic [3:0]        alu_op,
    output logic [39:0]       alu_in0,
    output logic [39:0]       alu_in1,
    input  logic [39:0]       alu_out,
    input  logic              alu_zf
);

    localparam logic [CNT_W-1:0] c_max_moves = CNT_W'(MAX_MOVES);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t             r_state;
    logic [39:0]        r_board;
    logic [39:0]        r_goal;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_solved;
    logic               r_bad;
    logic               r_illegal;
    logic [3:0]         r_alu_op;
    logic [39:0]        r_alu_in0;
    logic [39:0]        r_alu_in1;

    logic               w_legal;
    logic [3:0]         w_mv_op;
    logic [1:0]         w_inv_code;
    logic               w_start_bad;

    puzzle_move_legal u_legal (
        .i_pos      (blank_of(r_board)),
        .i_code     (mv_code),
        .o_legal    (w_legal),
        .o_opcode   (w_mv_op),
        .o_inv_code (w_inv_code)
    );

    assign w_start_bad = (blank_of(start_board) > MAX_POS);

`ifdef UNDO_EN
    localparam int HW = $clog2(UNDO_DEPTH + 1);

    logic [1:0]    r_hist [UNDO_DEPTH];
    logic [HW-1:0] r_hist_cnt;
    logic          r_dec;
    logic          w_hist_empty;
    logic          w_hist_full;
    logic [HW-1:0] w_top_idx;
    logic [1:0]    w_top;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;

    assign w_hist_empty = (r_hist_cnt == '0);
    assign w_hist_full  = (r_hist_cnt == HW'(UNDO_DEPTH));
    assign w_top_idx    = r_hist_cnt - HW'(1);
    assign w_clear      = (r_state == S_IDLE) && start_valid;
    assign w_pop        = (r_state == S_WAIT_MV) && mv_undo && !w_hist_empty;
    assign w_push       = (r_state == S_WAIT_MV) && !mv_undo && mv_valid && w_legal;

    // The history stores inverse codes so an undo is a direct lookup
    always_comb begin
        w_top = 2'd0;
        for (int i = 0; i < UNDO_DEPTH; i++) begin
            if (HW'(i) == w_top_idx) begin
                w_top = r_hist[i];
            end
        end
    end

    // History LIFO; a push into a full stack shifts out the oldest entry
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_hist_cnt <= '0;
            for (int i = 0; i < UNDO_DEPTH; i++) begin
                r_hist[i] <= 2'd0;
            end
        end else if (w_pop) begin
            r_hist_cnt <= w_top_idx;
        end else if (w_push) begin
            if (w_hist_full) begin
                for (int i = 0; i < UNDO_DEPTH - 1; i++) begin
                    r_hist[i] <= r_hist[i+1];
                end
                r_hist[UNDO_DEPTH-1] <= w_inv_code;
            end else begin
                for (int i = 0; i < UNDO_DEPTH; i++) begin
                    if (HW'(i) == r_hist_cnt) begin
                        r_hist[i] <= w_inv_code;
                    end
                end
                r_hist_cnt <= r_hist_cnt + HW'(1);
            end
        end
    end
`else
    logic w_unused_inv;
    assign w_unused_inv = ^w_inv_code;
`endif

    // Main control FSM; ALU drive is registered so it is stable for the
    // whole CHECK / APPLY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_board   <= '0;
            r_goal    <= '0;
            r_cnt     <= '0;
            r_solved  <= 1'b0;
            r_bad     <= 1'b0;
            r_illegal <= 1'b0;
            r_alu_op  <= OP_NOP;
            r_alu_in0 <= '0;
            r_alu_in1 <= '0;
`ifdef UNDO_EN
            r_dec     <= 1'b0;
`endif
        end else begin
            r_illegal <= 1'b0;
            r_alu_op  <= OP_NOP;
            r_alu_in0 <= '0;
            r_alu_in1 <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_board <= start_board;
                        r_goal  <= goal_board;
                        r_cnt   <= '0;
                        if (w_start_bad) begin
                            r_state  <= S_DONE;
                            r_bad    <= 1'b1;
                            r_solved <= 1'b0;
                        end else begin
                            r_state   <= S_CHECK;
                            r_alu_op  <= COMP;
                            r_alu_in0 <= goal_board;
                            r_alu_in1 <= start_board;
                        end
                    end
                end
                S_CHECK: begin
                    if (alu_zf) begin
                        r_state  <= S_DONE;
                        r_solved <= 1'b1;
                    end else if (r_cnt == c_max_moves) begin
                        r_state  <= S_DONE;
                        r_solved <= 1'b0;
                    end else begin
                        r_state <= S_WAIT_MV;
                    end
                end
                S_WAIT_MV: begin
`ifdef UNDO_EN
                    if (mv_undo) begin
                        if (w_hist_empty) begin
                            r_illegal <= 1'b1;
                        end else begin
                            r_state   <= S_APPLY;
                            r_dec     <= 1'b1;
                            r_alu_op  <= op_of_code(w_top);
                            r_alu_in1 <= r_board;
                        end
                    end else
`endif
                    if (mv_valid) begin
                        if (w_legal) begin
                            r_state   <= S_APPLY;
                            r_alu_op  <= w_mv_op;
                            r_alu_in1 <= r_board;
`ifdef UNDO_EN
                            r_dec     <= 1'b0;
`endif
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_APPLY: begin
                    r_board   <= alu_out;
`ifdef UNDO_EN
                    r_cnt     <= r_dec ? (r_cnt - c_one) : (r_cnt + c_one);
`else
                    r_cnt     <= r_cnt + c_one;
`endif
                    r_state   <= S_CHECK;
                    r_alu_op  <= COMP;
                    r_alu_in0 <= r_goal;
                    r_alu_in1 <= alu_out;
                end
                S_DONE: begin
                    if (done_ack) begin
                        r_state  <= S_IDLE;
                        r_solved <= 1'b0;
                        r_bad    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign mv_ready    = (r_state == S_WAIT_MV);
    assign done        = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign mv_illegal  = r_illegal;
    assign solved      = r_solved;
    assign bad_board   = r_bad;
    assign move_cnt    = r_cnt;
    assign board_out   = r_board;
    assign alu_op      = r_alu_op;
    assign alu_in0     = r_alu_in0;
    assign alu_in1     = r_alu_in1;

endmodule
`default_nettype wire

// File: doc/puzzle_move_sequencer.md
Name: puzzle_move_sequencer

Overview:
- Controller that sequences the shared 40-bit 8-puzzle ALU.
- Accepts a start board and a goal board, then a stream of blank-tile moves.
- Rejects illegal moves; applies legal ones through the ALU's TO_UP/TO_DOWN/to_right/TO_LEFT ops and checks each result against the goal with COMP.
- Sits between the search/host logic and the ALU instance; it is the only driver of the ALU op/in0/in1 inputs.

Parameters:
- MAX_MOVES, 31, moves applied before giving up with solved=0 (1..2^CNT_W-1).
- CNT_W, 8, width of move counter.
- UNDO_DEPTH, 8, LIFO depth of move history (used only with UNDO_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start_valid  in  1  start request
- start_ready  out  1  high only in IDLE
- start_board  in  40  [39:36] blank position 0..8; [35:0] tiles, nibble per cell
- goal_board  in  40  target board
- mv_valid  in  1  move offered
- mv_ready  out  1  high only in WAIT_MV
- mv_code  in  2  0=UP, 1=DOWN, 2=LEFT, 3=RIGHT (direction the blank moves)
- mv_illegal  out  1  one-cycle pulse: offered move rejected
- done  out  1  held high in DONE
- done_ack  in  1  releases DONE back to IDLE
- solved  out  1  valid while done=1
- bad_board  out  1  valid while done=1; start blank field >8
- busy  out  1  state != IDLE
- move_cnt  out  CNT_W  legal moves applied
- board_out  out  40  current board register
- alu_op  out  4  ALU opcode
- alu_in0  out  40  ALU operand 0
- alu_in1  out  40  ALU operand 1
- alu_out  in  40  ALU result (combinational)
- alu_zf  in  1  ALU zero/equal flag (combinational)

Behaviour:
- Reset (rst=1 at a clk edge), including mid-operation: state=IDLE; board/goal/move_cnt=0; done, solved, bad_board, mv_illegal=0; alu_op=OP_NOP; alu_in0 and alu_in1=0. Any in-flight move is discarded.
- FSM states: IDLE, CHECK, WAIT_MV, APPLY, DONE.
- IDLE:
  - On start_valid, latch start_board and goal_board and clear move_cnt.
  - If blank field >8, go to DONE with bad_board=1, solved=0.
  - Otherwise go to CHECK.
- CHECK (1 cycle):
  - Drive alu_op=COMP, alu_in0=goal, alu_in1=board; sample alu_zf at the edge.
  - zf=1: go to DONE with solved=1.
  - zf=0 and move_cnt==MAX_MOVES: go to DONE with solved=0.
  - Otherwise go to WAIT_MV.
- WAIT_MV:
  - mv_ready=1. Legality is computed combinationally from blank position p:
    - UP needs p>=3.
    - DOWN needs p<=5.
    - LEFT needs p mod 3 != 0.
    - RIGHT needs p mod 3 != 2.
  - Illegal move on a valid&ready cycle: consumed, mv_illegal pulses next cycle, board and count unchanged, stay in WAIT_MV.
  - Legal move: latch the opcode and go to APPLY.
- APPLY (1 cycle):
  - Drive the latched move op with alu_in1=board.
  - At the edge: board<=alu_out, move_cnt+1, go to CHECK.
- Latency:
  - Start to first mv_ready: 2 cycles.
  - Legal move to next mv_ready or done: 3 cycles.
- DONE:
  - done=1; solved and bad_board are held.
  - On done_ack go to IDLE and clear done, solved and bad_board.
  - start_valid is ignored until then.
- move_cnt never wraps; MAX_MOVES caps it.
- Outside CHECK and APPLY: alu_op=OP_NOP, operands=0.

Optional Feature:
- UNDO_EN defined:
  - Adds the mv_undo input (1 bit), sampled only in WAIT_MV and taking priority over mv_valid.
  - Keeps a UNDO_DEPTH LIFO of applied move codes.
  - An undo pops the top entry and issues the inverse op in APPLY (UP<->DOWN, LEFT<->RIGHT), with move_cnt-1.
  - Undo with the LIFO empty pulses mv_illegal.
  - A push to a full LIFO drops the oldest entry.
  - The LIFO is cleared on start and on reset.
- UNDO_EN undefined: no port, no LIFO, no behaviour change.

Decomposition:
- Shared package holds:
  - ALU opcodes: COMP, TO_UP, TO_DOWN, to_right, TO_LEFT, OP_NOP.
  - Move-code constants.
  - Board field slices: blank [39:36].
  - FSM state encoding.
- Natural sub-module: puzzle_move_legal (combinational: p, mv_code -> legal, opcode, inverse code).

Test Plan:
- start_board==goal_board=40'h0_12345678_0 -> done=1, solved=1, move_cnt=0, exactly 2 cycles after start accept; no move ops issued.
- Blank p=4, goal equal to that board after UP -> mv_code=0 gives alu_op=TO_UP for 1 cycle; then done=1, solved=1, move_cnt=1.
- Blank p=0, mv_code=0 (UP) -> mv_illegal 1-cycle pulse, board_out unchanged, move_cnt=0, mv_ready back high.
- MAX_MOVES=2, p=4, moves LEFT then RIGHT, unsolved -> after the second CHECK, done=1, solved=0, move_cnt=2.
- start_board blank field 4'h9 -> done=1, bad_board=1; alu_op stays OP_NOP throughout.
- rst asserted during APPLY -> next cycle state IDLE, start_ready=1, board_out=0, move_cnt=0; UNDO_EN build: undo after DOWN restores the original board, move_cnt=0.
